// File: rtl/univ_sft_reg.sv
// Universal shift register: parallel load, single-step shift and a
// counted auto-run with start/busy/done handshake.
module univ_sft_reg #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] db,
  input  logic             sft,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic             start,
  input  logic [CNTW-1:0]  cnt,
  output logic [WIDTH-1:0] qb,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             sin_q, sin_d;

  logic             s_dir;
  logic [1:0]       s_mode;
  logic             s_sin;
  logic [WIDTH:0]   sh;

  // One shift step; returns {bit shifted out, new contents}.
  function automatic logic [WIDTH:0] shf(
    input logic [WIDTH-1:0] q,
    input logic             d,
    input logic [1:0]       m,
    input logic             s
  );
    logic f;
    logic o;
    logic [WIDTH-1:0] r;
    if (!d) begin
      o = q[0];
      unique case (m)
        2'b01:   f = q[WIDTH-1];
        2'b10:   f = q[0];
        default: f = s;
      endcase
      r = {f, q[WIDTH-1:1]};
    end else begin
      o = q[WIDTH-1];
      unique case (m)
        2'b01:   f = 1'b0;
        2'b10:   f = q[WIDTH-1];
        default: f = s;
      endcase
      r = {q[WIDTH-2:0], f};
    end
    return {o, r};
  endfunction

  // Shift controls: latched copies while running, live inputs when idle.
  always_comb begin
    s_dir  = (state_q == RUN) ? dir_q  : dir;
    s_mode = (state_q == RUN) ? mode_q : mode;
    s_sin  = (state_q == RUN) ? sin_q  : sin;
    sh     = shf(qb_q, s_dir, s_mode, s_sin);
  end

  // Next-state: load beats everything, then start, then single shift.
  always_comb begin
    state_d = state_q;
    qb_d    = qb_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    sin_d   = sin_q;
    if (load) begin
      qb_d    = db;
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cnt == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              busy_d  = 1'b1;
              cnt_d   = cnt;
              dir_d   = dir;
              mode_d  = mode;
              sin_d   = sin;
            end
          end else if (sft) begin
            qb_d   = sh[WIDTH-1:0];
            sout_d = sh[WIDTH];
          end
        end
        RUN: begin
          qb_d   = sh[WIDTH-1:0];
          sout_d = sh[WIDTH];
          cnt_d  = cnt_q - CNTW'(1);
          if (cnt_q == CNTW'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      qb_q    <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      sin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qb_q    <= qb_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      sin_q   <= sin_d;
    end
  end

  assign qb   = qb_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_sft_reg.sv
// Bench for univ_sft_reg: directed cases plus random traffic
// checked against an arithmetic reference model.
module tb_univ_sft_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          load;
  logic [W-1:0]  db;
  logic          sft;
  logic          dir;
  logic [1:0]    mode;
  logic          sin;
  logic          start;
  logic [CW-1:0] cnt;
  logic [W-1:0]  qb;
  logic          sout;
  logic          busy;
  logic          done;

  univ_sft_reg #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .clr(clr), .load(load), .db(db),
    .sft(sft), .dir(dir), .mode(mode), .sin(sin),
    .start(start), .cnt(cnt), .qb(qb), .sout(sout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model state
  int m_q, m_sout, m_busy, m_done, m_rem;
  int m_dir, m_mode, m_sin;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_rem = 0;
  endfunction

  function automatic void m_shift(int d, int md, int s);
    int msb, mask, o;
    msb  = 1 << (W - 1);
    mask = (1 << W) - 1;
    if (md == 3) md = 0;
    if (d == 0) begin
      o = m_q & 1;
      if (md == 0)      m_q = (m_q >> 1) | (s ? msb : 0);
      else if (md == 1) m_q = (m_q >> 1) | (m_q & msb);
      else              m_q = (m_q >> 1) | (o ? msb : 0);
    end else begin
      o = (m_q >> (W - 1)) & 1;
      if (md == 0)      m_q = ((m_q << 1) | s) & mask;
      else if (md == 1) m_q = (m_q << 1) & mask;
      else              m_q = ((m_q << 1) | o) & mask;
    end
    m_sout = o;
  endfunction

  function automatic void m_edge();
    m_done = 0;
    if (load) begin
      m_q = int'(db);
      m_busy = 0;
    end else if (m_busy == 0) begin
      if (start) begin
        if (cnt == 0) m_done = 1;
        else begin
          m_busy = 1; m_rem = int'(cnt);
          m_dir = int'(dir); m_mode = int'(mode); m_sin = int'(sin);
        end
      end else if (sft) begin
        m_shift(int'(dir), int'(mode), int'(sin));
      end
    end else begin
      m_shift(m_dir, m_mode, m_sin);
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endfunction

  task automatic cmp(input string tag);
    chk({tag, ".qb"},   32'(qb),   32'(m_q));
    chk({tag, ".sout"}, 32'(sout), 32'(m_sout));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".excl"}, 32'(busy & done), 32'd0);
  endtask

  task automatic step(input string tag);
    m_edge();
    @(posedge clk);
    #1;
    cmp(tag);
  endtask

  task automatic idle();
    load = 0; sft = 0; start = 0;
  endtask

  initial begin
    clr = 1; load = 0; db = '0; sft = 0; dir = 0; mode = 0;
    sin = 0; start = 0; cnt = '0;
    m_reset();
    m_dir = 0; m_mode = 0; m_sin = 0;
    @(posedge clk); #1;
    cmp("reset");
    clr = 0;

    // 1: load A5, logical right shift
    load = 1; db = 8'hA5; step("t1.ld");
    idle(); sft = 1; dir = 0; mode = 2'b00; sin = 0; step("t1.sft");
    chk("t1.qb", 32'(qb), 32'h52);
    chk("t1.sout", 32'(sout), 32'd1);
    idle(); step("t1.idle");

    // 2: arithmetic right run of 3
    load = 1; db = 8'h81; step("t2.ld");
    idle(); start = 1; cnt = 3; dir = 0; mode = 2'b01; step("t2.st");
    chk("t2.busy0", 32'(busy), 32'd1);
    idle(); dir = 1; mode = 2'b10;
    step("t2.r1");
    step("t2.r2");
    chk("t2.busy2", 32'(busy), 32'd1);
    step("t2.r3");
    chk("t2.qb", 32'(qb), 32'hF0);
    chk("t2.sout", 32'(sout), 32'd0);
    chk("t2.done", 32'(done), 32'd1);
    step("t2.after");
    chk("t2.done1", 32'(done), 32'd0);

    // 3: rotate left run of 4
    load = 1; db = 8'h81; step("t3.ld");
    idle(); start = 1; cnt = 4; dir = 1; mode = 2'b10; step("t3.st");
    idle();
    for (int i = 0; i < 4; i++) step("t3.run");
    chk("t3.qb", 32'(qb), 32'h18);
    chk("t3.done", 32'(done), 32'd1);
    step("t3.after");

    // 4: zero-length run
    load = 1; db = 8'h3C; step("t4.ld");
    idle(); start = 1; cnt = 0; step("t4.st");
    chk("t4.busy", 32'(busy), 32'd0);
    chk("t4.done", 32'(done), 32'd1);
    chk("t4.qb", 32'(qb), 32'h3C);
    idle(); step("t4.after");
    chk("t4.done1", 32'(done), 32'd0);

    // 5: load aborts a run
    start = 1; cnt = 9; dir = 0; mode = 2'b00; sin = 1; step("t5.st");
    idle(); step("t5.r1");
    load = 1; db = 8'h77; step("t5.ab");
    chk("t5.qb", 32'(qb), 32'h77);
    chk("t5.busy", 32'(busy), 32'd0);
    idle(); step("t5.after");
    chk("t5.done", 32'(done), 32'd0);

    // 6: asynchronous clear mid-run
    start = 1; cnt = 5; dir = 1; mode = 2'b00; sin = 1; step("t6.st");
    idle(); step("t6.r1");
    #3 clr = 1;
    #1;
    m_reset();
    chk("t6.qb", 32'(qb), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);
    chk("t6.done", 32'(done), 32'd0);
    @(posedge clk); #1;
    cmp("t6.held");
    clr = 0;
    step("t6.after");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom % 16) == 0;
      db    = W'($urandom);
      start = ($urandom % 5) == 0;
      sft   = ($urandom % 2) == 0;
      dir   = 1'($urandom);
      mode  = 2'($urandom);
      sin   = 1'($urandom);
      cnt   = CW'($urandom_range(0, 15));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
